// File: rtl/alu_driver.sv
// alu_driver -- command sequencer in front of a combinational ALU.
//
// Commands {opcode, a, b} are queued in a 4-entry FIFO. A three-state FSM
// (IDLE -> ISSUE -> RESP) pops one command at a time. It presents the command
// to the external ALU on registered outputs and captures the ALU result in
// ISSUE. It then holds the result on the response channel until the consumer
// accepts it. Responses come back strictly in command order.
//
// Optional feature macro: ALU_DRV_CHECK_EN
//   defined   : rsp_err flags an inconsistent zero flag, a divide by zero
//               (opcode 4'b0011 with b == 0) or an opcode above 4'b1001.
//   undefined : rsp_err is tied to 0 and no check logic exists.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready = FIFO not full)
//   cmd_opcode, cmd_a, cmd_b        command payload
//   alu_opcode, alu_a, alu_b        registered operands driven to the ALU
//   alu_y, alu_zero, alu_overflow   ALU results
//   rsp_valid/rsp_ready             response handshake
//   rsp_y, rsp_zero, rsp_overflow   captured ALU results
//   rsp_err                         consistency check result (see above)
//   busy                            FIFO non-empty or FSM not IDLE

module alu_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic       rsp_err,
  output logic       busy
);

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [3:0] fifo_op [DEPTH];
  logic [7:0] fifo_a  [DEPTH];
  logic [7:0] fifo_b  [DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic load_rsp;

  // Command FIFO
  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens a slot for a push into a full FIFO.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_opcode;
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
    end
  end

  // Sequencer FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load_rsp   = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        load_rsp   = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy = !fifo_empty || (state != IDLE);

  // ALU operand registers: loaded on pop and held until the next pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opcode <= 4'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
    end else if (pop) begin
      alu_opcode <= fifo_op[rd_ptr];
      alu_a      <= fifo_a[rd_ptr];
      alu_b      <= fifo_b[rd_ptr];
    end
  end

  // Response capture at the closing edge of ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_y        <= 8'd0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (load_rsp) begin
      rsp_y        <= alu_y;
      rsp_zero     <= alu_zero;
      rsp_overflow <= alu_overflow;
    end
  end

`ifdef ALU_DRV_CHECK_EN
  // Flags a zero flag that disagrees with the result, a divide by zero, or an
  // opcode outside the defined range 0..9.
  function automatic logic check_err(input logic [3:0] op,
                                     input logic [7:0] b,
                                     input logic [7:0] y,
                                     input logic       zero);
    logic zero_bad;
    logic div_zero;
    logic op_bad;
    zero_bad  = (zero != (y == 8'h00));
    div_zero  = (op == 4'b0011) && (b == 8'h00);
    op_bad    = (op > 4'b1001);
    return zero_bad || div_zero || op_bad;
  endfunction

  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load_rsp) begin
      err_q <= check_err(alu_opcode, alu_b, alu_y, alu_zero);
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver -- randomized and directed bench for alu_driver.
// A behavioural ALU drives alu_y/alu_zero/alu_overflow from the DUT operands.
// A transaction-level reference model (queue of pending commands plus the
// command in flight) predicts cmd_ready, busy, rsp_valid and every response.

module tb_alu_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic       alu_zero;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_zero;
  logic       rsp_overflow;
  logic       rsp_err;
  logic       busy;

  always #5 clk = ~clk;

  alu_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU: returns {overflow, zero, y}.
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] y;
    logic       ov;
    ov = 1'b0;
    case (op)
      4'd0: begin
        y  = a + b;
        ov = (a[7] == b[7]) && (y[7] != a[7]);
      end
      4'd1: begin
        y  = a - b;
        ov = (a[7] != b[7]) && (y[7] != a[7]);
      end
      4'd2:    y = a & b;
      4'd3:    y = (b == 8'h00) ? 8'hFF : a / b;
      4'd4:    y = a | b;
      4'd5:    y = a ^ b;
      default: y = a ^ {op, op};
    endcase
    return {ov, (y == 8'h00), y};
  endfunction

  // When set, the ALU lies: y = 1 with the zero flag raised.
  logic       bad_zero = 1'b0;
  logic [9:0] alu_r;

  always_comb begin
    alu_r = alu_ref(alu_opcode, alu_a, alu_b);
    if (bad_zero) alu_r = 10'b0_1_00000001;
    {alu_overflow, alu_zero, alu_y} = alu_r;
  end

  function automatic logic err_ref(input logic [3:0] op, input logic [7:0] b,
                                   input logic [7:0] y, input logic z);
`ifdef ALU_DRV_CHECK_EN
    return (z != (y == 8'h00)) || (op == 4'd3 && b == 8'h00) || (op > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: commands waiting, command in flight and its phase
  // (0 = none, 1 = being issued, 2 = response offered).
  logic [19:0] pend[$];
  logic [19:0] cur;
  int          phase = 0;

  // One clock cycle. Entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic rr);
    logic [9:0] r;
    logic       acc;
    chk("cmd_ready", cmd_ready, pend.size() < 4);
    chk("busy", busy, (pend.size() > 0) || (phase != 0));
    chk("rsp_valid", rsp_valid, phase == 2);
    if (phase == 1) begin
      chk("alu_bus", {alu_opcode, alu_a, alu_b}, cur);
    end
    if (phase == 2) begin
      r = alu_ref(cur[19:16], cur[15:8], cur[7:0]);
      if (bad_zero) r = 10'b0_1_00000001;
      chk("rsp_y", rsp_y, r[7:0]);
      chk("rsp_zero", rsp_zero, r[8]);
      chk("rsp_overflow", rsp_overflow, r[9]);
      chk("rsp_err", rsp_err, err_ref(cur[19:16], cur[7:0], r[7:0], r[8]));
    end
    cmd_valid  = v;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    rsp_ready  = rr;
    acc = v && (pend.size() < 4);
    if (phase == 0 && pend.size() > 0) begin
      cur   = pend.pop_front();
      phase = 1;
    end else if (phase == 1) begin
      phase = 2;
    end else if (phase == 2 && rr) begin
      phase = 0;
    end
    if (acc) pend.push_back({op, a, b});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 8'd0, 8'd0, rr);
  endtask

  // Reset with cmd_valid and rsp_ready asserted: both must be ignored.
  task automatic do_reset();
    rst_n      = 1'b0;
    cmd_valid  = 1'b1;
    rsp_ready  = 1'b1;
    cmd_opcode = 4'($urandom);
    cmd_a      = 8'($urandom);
    cmd_b      = 8'($urandom);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    pend.delete();
    phase = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_y, rsp_zero, rsp_overflow, rsp_err}, 0);
    chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    rsp_ready  = 1'b0;
    cmd_opcode = 4'd0;
    cmd_a      = 8'd0;
    cmd_b      = 8'd0;
    do_reset();

    // ADD 0x70 + 0x20: response three cycles after acceptance.
    cycle(1'b1, 4'd0, 8'h70, 8'h20, 1'b1);
    idle(2, 1'b1);
    chk("add_valid_c3", rsp_valid, 1);
    chk("add_y", rsp_y, 8'h90);
    chk("add_ovf", rsp_overflow, 1);
    chk("add_zero", rsp_zero, 0);
    chk("add_err", rsp_err, 0);
    idle(3, 1'b1);

    // Back-pressure: five pushes fill the FIFO with one command issued.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 4'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 1'b0);
    chk("full_cmd_ready", cmd_ready, 0);
    idle(3, 1'b0);
    // Keep offering while full so pops coincide with rejected pushes.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 4'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 1'b1);
    idle(40, 1'b1);

    // Divide by zero and an out-of-range opcode.
    cycle(1'b1, 4'd3, 8'h10, 8'h00, 1'b1);
    cycle(1'b1, 4'b1100, 8'h5A, 8'h3C, 1'b1);
    idle(10, 1'b1);

    // Consistent zero result, then an ALU with a lying zero flag.
    cycle(1'b1, 4'd1, 8'h05, 8'h05, 1'b1);
    idle(5, 1'b1);
    bad_zero = 1'b1;
    cycle(1'b1, 4'd0, 8'h01, 8'h02, 1'b1);
    idle(5, 1'b1);
    bad_zero = 1'b0;

    // Reset while a response is pending and two commands are queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 1'b0);
    idle(1, 1'b0);
    chk("pre_rst_valid", rsp_valid, 1);
    do_reset();
    idle(10, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cycle(($urandom_range(0, 1) == 1), 4'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < 6));
    idle(40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
